// File: rtl/led_demux_scan_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | led_demux_scan_tx_if                                                 |
// | Frame request and channel outputs between control and LED demux tx. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface led_demux_scan_tx_if;
   logic       start;
   logic [7:0] data;
   logic [2:0] sel;
   logic       x;
   logic       valid;
   logic       busy;
   logic       done;

   modport master (
      output start,
      output data,
      input  sel,
      input  x,
      input  valid,
      input  busy,
      input  done
   );

   modport slave (
      input  start,
      input  data,
      output sel,
      output x,
      output valid,
      output busy,
      output done
   );
endinterface
`default_nettype wire

// File: rtl/led_demux_scan_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | led_demux_scan_tx                                                    |
// | Latches an 8-bit pattern and scans it out as (sel, x), ch 7 to 0.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module led_demux_scan_tx #(
   parameter int DWELL = 4,
   parameter int CNT_W = 16
) (
   input  wire logic          clk,
   input  wire logic          rst,
   led_demux_scan_tx_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DWELL - 1);

   state_t           r_state;
   logic [7:0]       r_shreg;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_sel;
   logic             r_x;
   logic             r_valid;
   logic             r_busy;
   logic             r_done;
   logic [2:0]       w_sel_next;

   assign w_sel_next = r_sel - 3'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_shreg <= 8'h00;
         r_cnt   <= '0;
         r_sel   <= 3'd0;
         r_x     <= 1'b0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_sel   <= 3'd0;
               r_x     <= 1'b0;
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_cnt   <= '0;
               if (bus.start) begin
                  r_shreg <= bus.data;
                  r_sel   <= 3'd7;
                  r_x     <= bus.data[7];
                  r_valid <= 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (r_cnt == C_CNT_LAST) begin
                  r_cnt <= '0;
                  if (r_sel != 3'd0) begin
                     r_sel <= w_sel_next;
                     r_x   <= r_shreg[w_sel_next];
                  end else begin
                     // Frame finished: blank the demux and flag completion.
                     r_x     <= 1'b0;
                     r_valid <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= ST_DONE;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_sel   <= 3'd0;
               r_x     <= 1'b0;
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.sel   = r_sel;
   assign bus.x     = r_x;
   assign bus.valid = r_valid;
   assign bus.busy  = r_busy;
   assign bus.done  = r_done;

endmodule
`default_nettype wire

// File: doc/led_demux_scan_tx.md
Name: led_demux_scan_tx

Overview:
Transmit end of the 1-to-8 LED demux interface. Latches an 8-bit pattern on a start request and walks it out one channel at a time as a (sel, x) pair: sel = channel index, x = that channel's bit, channels 7 down to 0. Each channel is held for a programmable dwell, so a downstream 1-to-8 demux lights LED[sel] with x. Sits between control logic and the LED demux, one frame per request.

Parameters:
DWELL, 4, clock cycles each channel is held; legal range 1 to 2^CNT_W-1
CNT_W, 16, width of the internal dwell counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  frame request; sampled only in IDLE
data  in  8  pattern to transmit; latched on accepted start
sel  out  3  current channel index to the demux select
x  out  1  current channel bit to the demux data input
valid  out  1  high while sel/x carry a channel of the frame
busy  out  1  high from frame accept until the end of the DONE cycle
done  out  1  one-cycle pulse after the last channel (index 0) completes

Behaviour:
- Reset: clock and reset are fixed as one clock, clk; reset rst is asynchronous and active-high. On rst: state=IDLE; sel=3'b000, x=0, valid=0, busy=0, done=0; shift register and dwell counter cleared. Reset mid-frame aborts the frame immediately, with no done pulse.
- FSM states: IDLE, SEND, DONE.
- IDLE: outputs sel=0, x=0, valid=0, busy=0, done=0. A clock edge with start=1 latches data into shreg, loads sel=7, x=data[7], sets the dwell counter to 0 and goes to SEND. Outputs update on that same edge, so valid=1 and busy=1 from the next cycle.
- SEND: sel/x are held for exactly DWELL cycles per channel, and the dwell counter increments each cycle.
  - When the counter reaches DWELL-1 and sel>0: sel decrements, x takes shreg[sel-1], and the counter returns to 0.
  - When the counter reaches DWELL-1 and sel=0: go to DONE.
- DONE: lasts one cycle, with done=1, busy=1, valid=0, x=0, sel=0. The next state is always IDLE.
- Latency: start accepted at edge N. valid is high for cycles N+1 .. N+8*DWELL. done is high in cycle N+8*DWELL+1. The earliest next accept is at the edge ending that DONE cycle +1, i.e. start must be sampled in IDLE.
- start while busy, including during the DONE cycle, is ignored; it is not queued.
- data changes after accept have no effect on the current frame; only the latched copy is transmitted.
- Channel order is fixed 7,6,...,0, with sel=k carrying original data[k]. This matches the demux mapping sel=k -> LED[k].
- x=0 whenever valid=0, so the downstream demux shows all LEDs dark between frames.
- DWELL=1: a new channel every cycle, and the frame occupies 8 valid cycles.
- All outputs are registered; there is no combinational path from start/data to the outputs.

Test Plan:
- Reset check: assert rst asynchronously mid-cycle -> sel=0, x=0, valid=0, busy=0, done=0 immediately; start held high during reset is not accepted.
- Nominal frame, DWELL=4, data=8'hA5, 1-cycle start -> sel=7,6,5,4,3,2,1,0, each for 4 cycles; x=1,0,1,0,0,1,0,1; valid high for 32 cycles; done high in exactly cycle 33 after accept; busy high for 33 cycles.
- Start while busy: second start, with data=8'hFF, at cycle 10 of a frame of 8'h00, plus data toggled every cycle -> x stays 0 for all 8 channels, with no second frame.
- Start during DONE, DWELL=1, data=8'h81: pulse start in the done cycle -> ignored. Pulse start in the next IDLE cycle -> new frame with x=1,0,0,0,0,0,0,1.
- Reset mid-frame: DWELL=2, data=8'hFF, assert rst during sel=4 -> outputs zero at once, done never pulses. After release, a new start with 8'h01 transmits x=1 only on sel=0.
- Continuous start held high, DWELL=3 -> back-to-back frames separated by exactly one DONE cycle and one IDLE cycle, with the dwell per channel always 3 cycles.
